// File: rtl/pdm_tx.sv
// pdm_tx -- PCM to 1-bit PDM transmitter.
//
// Signed PCM samples arrive over a valid/ready handshake and wait in a small FIFO.
// One sample is taken from the FIFO per output frame of OSR PDM bits. A first-order
// (or optionally second-order) sigma-delta modulator turns that sample into a
// pulse-density stream. The block also generates the matching PDM bit clock.
//
// Build option:
//   PDM_TX_SECOND_ORDER_EN  when defined, builds the second-order modulator with an
//                           input clamp. When undefined, builds the first-order
//                           modulator with no clamp.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   data_in      signed PCM sample
//   valid_in     data_in valid
//   ready_out    FIFO can accept (a transfer happens when valid_in && ready_out)
//   pdm_clk_out  PDM bit clock, 50% duty, CLK_DIV clk cycles per bit
//   pdm_out      PDM data, changes together with the falling edge of pdm_clk_out
//   underrun     one-cycle pulse: a frame boundary found the FIFO empty after the first pop
//   fifo_level   current FIFO occupancy
module pdm_tx #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CLK_DIV    = 32,
  parameter int unsigned OSR        = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [WIDTH-1:0]         data_in,
  input  logic                            valid_in,
  output logic                            ready_out,
  output logic                            pdm_clk_out,
  output logic                            pdm_out,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(OSR);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  // Working width for the integrator sums. It is wide enough that i2 + i1' - fb cannot wrap before saturation.
  localparam int unsigned ACC_W = WIDTH + 6;

  localparam logic signed [ACC_W-1:0] FB_MAG = ACC_W'(1) <<< (WIDTH - 1);
  localparam logic signed [ACC_W-1:0] I1_MAX = (ACC_W'(1) <<< (WIDTH + 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] I1_MIN = -(ACC_W'(1) <<< (WIDTH + 1));

  // Clock divider and bit/frame timing
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic             bit_tick, frame_end;

  assign bit_tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_end = bit_tick && (bit_cnt == BIT_W'(OSR - 1));
  assign div_nxt   = bit_tick ? '0 : div_cnt + DIV_W'(1);

  // Sample FIFO
  logic signed [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    push, pop, fifo_empty;

  assign fifo_empty = (fifo_level == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle. Gating with rst
  // keeps the handshake closed while the block is in reset.
  assign ready_out  = !rst && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push       = valid_in && ready_out;
  assign pop        = frame_end && !fifo_empty;

  // Modulator state
  logic signed [WIDTH-1:0] cur_sample;
  logic                    armed;       // set after the first pop; gates underrun reporting
  logic signed [WIDTH+1:0] i1, i1_new;
  logic signed [ACC_W-1:0] x_ext, fb, i1_sum;
  logic                    bit_new;

  function automatic logic signed [WIDTH+1:0] sat_i1(input logic signed [ACC_W-1:0] v);
    if (v > I1_MAX)      return I1_MAX[WIDTH+1:0];
    else if (v < I1_MIN) return I1_MIN[WIDTH+1:0];
    else                 return v[WIDTH+1:0];
  endfunction

`ifdef PDM_TX_SECOND_ORDER_EN
  localparam logic signed [ACC_W-1:0] I2_MAX = (ACC_W'(1) <<< (WIDTH + 3)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] I2_MIN = -(ACC_W'(1) <<< (WIDTH + 3));
  localparam logic signed [ACC_W-1:0] X_LIM  = ACC_W'(3) <<< (WIDTH - 3);

  logic signed [WIDTH+3:0] i2, i2_new;
  logic signed [ACC_W-1:0] i2_sum;

  function automatic logic signed [WIDTH+3:0] sat_i2(input logic signed [ACC_W-1:0] v);
    if (v > I2_MAX)      return I2_MAX[WIDTH+3:0];
    else if (v < I2_MIN) return I2_MIN[WIDTH+3:0];
    else                 return v[WIDTH+3:0];
  endfunction
`endif

  // NOTE: every signal driven here gets a value on every path, so that no latch is inferred.
  always_comb begin
    x_ext = ACC_W'(cur_sample);
`ifdef PDM_TX_SECOND_ORDER_EN
    // The second-order loop is only stable for inputs of about 3/4 of full scale or less.
    if (x_ext > X_LIM)       x_ext = X_LIM;
    else if (x_ext < -X_LIM) x_ext = -X_LIM;
`endif
    fb     = pdm_out ? FB_MAG : -FB_MAG;
    i1_sum = ACC_W'(i1) + x_ext - fb;
    i1_new = sat_i1(i1_sum);
`ifdef PDM_TX_SECOND_ORDER_EN
    i2_sum  = ACC_W'(i2) + ACC_W'(i1_new) - fb;
    i2_new  = sat_i2(i2_sum);
    bit_new = !i2_new[WIDTH+3];
`else
    bit_new = !i1_new[WIDTH+1];
`endif
  end

  // NOTE: the FIFO storage has no reset. Validity is tracked by the pointers and the level
  //       alone, so the array can map onto plain RAM or register cells without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // NOTE: state registers use non-blocking assignments only. Every register then sees
  //       the values from before the edge. For example, a pop at a frame boundary loads
  //       cur_sample while the modulator still uses the old sample on that tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      pdm_clk_out <= 1'b0;
      pdm_out     <= 1'b0;
      underrun    <= 1'b0;
      fifo_level  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cur_sample  <= '0;
      armed       <= 1'b0;
      i1          <= '0;
`ifdef PDM_TX_SECOND_ORDER_EN
      i2          <= '0;
`endif
    end else begin
      div_cnt     <= div_nxt;
      pdm_clk_out <= (div_nxt >= DIV_W'(CLK_DIV / 2));
      underrun    <= frame_end && fifo_empty && armed;

      if (bit_tick) begin
        bit_cnt <= (bit_cnt == BIT_W'(OSR - 1)) ? '0 : bit_cnt + BIT_W'(1);
        i1      <= i1_new;
`ifdef PDM_TX_SECOND_ORDER_EN
        i2      <= i2_new;
`endif
        pdm_out <= bit_new;
      end

      if (pop) begin
        cur_sample <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
        armed      <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_tx.sv
// tb_pdm_tx -- bench for pdm_tx with CLK_DIV=4, OSR=8, FIFO_DEPTH=4, WIDTH=16.
// A reference model follows the time-based rules of the block. It works with an
// absolute edge count, a sample queue and integer integrators, and it predicts every
// output on every cycle. Directed phases add checks of the handshake, the density,
// underrun reporting and reset behaviour.
module tb_pdm_tx;

  localparam int WIDTH      = 16;
  localparam int CLK_DIV    = 4;
  localparam int OSR        = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME      = CLK_DIV * OSR;

  localparam longint HALF   = longint'(1) << (WIDTH - 1);
  localparam longint I1_HI  = (longint'(1) << (WIDTH + 1)) - 1;
  localparam longint I1_LO  = -(longint'(1) << (WIDTH + 1));
  localparam longint I2_HI  = (longint'(1) << (WIDTH + 3)) - 1;
  localparam longint I2_LO  = -(longint'(1) << (WIDTH + 3));
  localparam longint X_LIM  = 3 * (longint'(1) << (WIDTH - 3));

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] data_in;
  logic                    valid_in;
  logic                    ready_out, pdm_clk_out, pdm_out, underrun;
  logic [LVL_W-1:0]        fifo_level;

  always #5 clk = ~clk;

  pdm_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .pdm_clk_out(pdm_clk_out), .pdm_out(pdm_out), .underrun(underrun), .fifo_level(fifo_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                      t;          // clk edges since reset was released
  logic signed [WIDTH-1:0] q[$];       // FIFO contents
  longint                  cur, i1, i2;
  bit                      armed, m_pdm, m_und;
  int                      sat_hits;

  // Phase statistics taken from the DUT outputs
  int ones, bits, unds, accs;

  function automatic longint sat(input longint v, input longint lo, input longint hi);
    if (v > hi) begin sat_hits++; return hi; end
    if (v < lo) begin sat_hits++; return lo; end
    return v;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic signed [WIDTH-1:0] d);
    bit acc, tick, fend;
    longint fb, x;
    if (r) begin
      t = 0; q.delete(); cur = 0; armed = 0; i1 = 0; i2 = 0; m_pdm = 0; m_und = 0;
      return;
    end
    acc   = v && (q.size() < FIFO_DEPTH);
    tick  = (t % CLK_DIV) == CLK_DIV - 1;
    fend  = tick && ((t / CLK_DIV) % OSR) == OSR - 1;
    m_und = 0;
    if (tick) begin
      fb = m_pdm ? HALF : -HALF;
      x  = cur;
`ifdef PDM_TX_SECOND_ORDER_EN
      if (x > X_LIM) x = X_LIM;
      if (x < -X_LIM) x = -X_LIM;
      i1    = sat(i1 + x - fb, I1_LO, I1_HI);
      i2    = sat(i2 + i1 - fb, I2_LO, I2_HI);
      m_pdm = (i2 >= 0);
`else
      i1    = sat(i1 + x - fb, I1_LO, I1_HI);
      m_pdm = (i1 >= 0);
`endif
    end
    if (fend) begin
      if (q.size() > 0) begin
        cur   = q.pop_front();
        armed = 1;
      end else if (armed) begin
        m_und = 1;
      end
    end
    if (acc) q.push_back(d);
    t++;
  endtask

  // One clk cycle: drive, step the model at the edge, compare all outputs #1 later.
  task automatic cycle(input bit r, input bit v, input logic signed [WIDTH-1:0] d);
    bit tick_seen;
    rst = r; valid_in = v; data_in = d;
    #1;
    if (!r && v && ready_out) accs++;
    @(posedge clk);
    tick_seen = !r && ((t % CLK_DIV) == CLK_DIV - 1);
    model_step(r, v, d);
    #1;
    check("pdm_out",     64'(pdm_out),     64'(m_pdm));
    check("pdm_clk_out", 64'(pdm_clk_out), 64'((t % CLK_DIV) >= CLK_DIV / 2));
    check("underrun",    64'(underrun),    64'(m_und));
    check("fifo_level",  64'(fifo_level),  64'(q.size()));
    check("ready_out",   64'(ready_out),   64'(!r && (q.size() < FIFO_DEPTH)));
    if (tick_seen) begin bits++; ones += int'(pdm_out); end
    unds += int'(underrun);
  endtask

  task automatic run(input int n, input bit v, input logic signed [WIDTH-1:0] d);
    repeat (n) cycle(1'b0, v, d);
  endtask

  // Reset with valid held high and junk data: nothing offered during reset may be accepted.
  task automatic do_reset(input int n);
    repeat (n) cycle(1'b1, 1'b1, 16'sh1234);
  endtask

  task automatic clr_stats();
    ones = 0; bits = 0; unds = 0; accs = 0;
  endtask

  initial begin
    int u_first, prev_lvl, first_pop_t, p;
    clr_stats();
    sat_hits = 0;

    // Reset state
    do_reset(3);
    check("rst_ready_low", 64'(ready_out), 64'(0));
    check("rst_pdm_clk",   64'(pdm_clk_out), 64'(0));

    // Backpressure, then zero input for density
    clr_stats();
    run(8, 1'b1, '0);
    check("bp_accepts",   64'(accs), 64'(FIFO_DEPTH));
    check("bp_level_full", 64'(fifo_level), 64'(FIFO_DEPTH));
    check("bp_ready_full", 64'(ready_out), 64'(0));
    run(FRAME - 8, 1'b1, '0);
    check("bp_ready_after_pop", 64'(ready_out), 64'(1));
    check("bp_level_after_pop", 64'(fifo_level), 64'(FIFO_DEPTH - 1));
    run(2 * FRAME, 1'b1, '0);
    clr_stats();
    run(8 * FRAME, 1'b1, '0);
    check("zero_bits",    64'(bits), 64'(8 * OSR));
    check("zero_density", 64'(ones >= 31 && ones <= 33), 64'(1));

    // Full scale positive and negative
    do_reset(1);
    run(2 * FRAME, 1'b1, 16'sh7FFF);
    clr_stats();
    run(7 * FRAME, 1'b1, 16'sh7FFF);
`ifdef PDM_TX_SECOND_ORDER_EN
    check("pos_fs_density", 64'(ones >= 46 && ones <= 52), 64'(1));
`else
    check("pos_fs_density", 64'(ones >= 7 * 7), 64'(1));
`endif
    do_reset(1);
    run(2 * FRAME, 1'b1, 16'sh8000);
    clr_stats();
    run(7 * FRAME, 1'b1, 16'sh8000);
`ifdef PDM_TX_SECOND_ORDER_EN
    check("neg_fs_density", 64'(ones >= 4 && ones <= 10), 64'(1));
`else
    check("neg_fs_density", 64'(ones <= 7), 64'(1));
`endif

    // Underrun: nothing before the first pop, then one pulse per empty boundary
    do_reset(1);
    clr_stats();
    run(2 * FRAME, 1'b0, '0);
    check("no_underrun_before_pop", 64'(unds), 64'(0));
    clr_stats();
    cycle(1'b0, 1'b1, 16'sh4000);
    run(4 * FRAME - 1, 1'b0, '0);
    u_first = unds;
    clr_stats();
    run(8 * FRAME, 1'b0, '0);
    check("underrun_count", 64'(u_first + unds), 64'(11));
    check("underrun_density", 64'(ones >= 45 && ones <= 51), 64'(1));

    // Reset mid-frame with three samples queued
    do_reset(1);
    run(3, 1'b1, 16'sh0100);
    run(12, 1'b0, '0);
    check("midrst_level_before", 64'(fifo_level), 64'(3));
    cycle(1'b1, 1'b1, 16'sh7777);
    check("midrst_level_flushed", 64'(fifo_level), 64'(0));
    prev_lvl    = 0;
    first_pop_t = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b1, WIDTH'($urandom));
      if (first_pop_t < 0 && int'(fifo_level) < prev_lvl) first_pop_t = t;
      prev_lvl = int'(fifo_level);
    end
    check("midrst_first_pop_t", 64'(first_pop_t), 64'(FRAME));

    // Random traffic: each frame has its own push rate, so the FIFO both fills and
    // underruns. The run has one reset in the middle.
    do_reset(1);
    for (int f = 0; f < 40; f++) begin
      if (f == 20) do_reset(1);
      p = int'($urandom_range(0, 8));
      for (int c = 0; c < FRAME; c++)
        cycle(1'b0, ($urandom_range(0, 99) < p), WIDTH'($urandom));
    end

`ifdef PDM_TX_SECOND_ORDER_EN
    // Clamped full scale, 1000 frames with no integrator saturation
    do_reset(1);
    run(2 * FRAME, 1'b1, 16'sh7FFF);
    sat_hits = 0;
    clr_stats();
    run(100 * FRAME, 1'b1, 16'sh7FFF);
    check("so_density", 64'(ones >= 692 && ones <= 708), 64'(1));
    run(898 * FRAME, 1'b1, 16'sh7FFF);
    check("so_no_saturation", 64'(sat_hits), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
